// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring integer divider with signed/unsigned mode,
// valid/ready handshakes, deterministic divide-by-zero result and a pass-through tag.
module seq_divider #(
  parameter int Size     = 32,
  parameter int TagWidth = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_signed,
  input  logic [Size-1:0]     a,
  input  logic [Size-1:0]     b,
  input  logic [TagWidth-1:0] in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [Size-1:0]     c,
  output logic [Size-1:0]     remainder,
  output logic                div_by_zero,
  output logic [TagWidth-1:0] out_tag
);

  localparam int CntW = $clog2(Size + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [Size-1:0]     prem_q, prem_d;
  logic [Size-1:0]     dvd_q, dvd_d;
  logic [Size-1:0]     abs_b_q, abs_b_d;
  logic                neg_q_q, neg_q_d;
  logic                neg_r_q, neg_r_d;
  logic [TagWidth-1:0] tag_q, tag_d;
  logic [Size-1:0]     c_q, c_d;
  logic [Size-1:0]     rem_out_q, rem_out_d;
  logic                dbz_q, dbz_d;
  logic [TagWidth-1:0] out_tag_q, out_tag_d;

  logic [Size:0]       trial;
  logic [Size:0]       diff;
  logic                trial_ge;
  logic [Size-1:0]     abs_a_in;
  logic [Size-1:0]     abs_b_in;

  // dvd_q doubles as the quotient: dividend bits shift out the top while
  // quotient bits shift in at the bottom, so after Size steps it holds q.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    dvd_d     = dvd_q;
    abs_b_d   = abs_b_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    tag_d     = tag_q;
    c_d       = c_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;
    out_tag_d = out_tag_q;

    abs_a_in  = (in_signed && a[Size-1]) ? (~a + 1'b1) : a;
    abs_b_in  = (in_signed && b[Size-1]) ? (~b + 1'b1) : b;
    trial     = {prem_q, dvd_q[Size-1]};
    diff      = trial - {1'b0, abs_b_q};
    trial_ge  = (trial >= {1'b0, abs_b_q});

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tag_d   = in_tag;
          neg_q_d = in_signed & (a[Size-1] ^ b[Size-1]);
          neg_r_d = in_signed & a[Size-1];
          dvd_d   = abs_a_in;
          abs_b_d = abs_b_in;
          prem_d  = '0;
          if (b == '0) begin
            c_d       = '1;
            rem_out_d = a;
            dbz_d     = 1'b1;
            out_tag_d = in_tag;
            state_d   = DONE;
          end else begin
            cnt_d   = CntW'(Size);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prem_d = trial_ge ? diff[Size-1:0] : trial[Size-1:0];
        dvd_d  = {dvd_q[Size-2:0], trial_ge};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        c_d       = neg_q_q ? (~dvd_q + 1'b1) : dvd_q;
        rem_out_d = neg_r_q ? (~prem_q + 1'b1) : prem_q;
        dbz_d     = 1'b0;
        out_tag_d = tag_q;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prem_q    <= '0;
      dvd_q     <= '0;
      abs_b_q   <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      tag_q     <= '0;
      c_q       <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prem_q    <= prem_d;
      dvd_q     <= dvd_d;
      abs_b_q   <= abs_b_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      tag_q     <= tag_d;
      c_q       <= c_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
      out_tag_q <= out_tag_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign c           = c_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_seq_divider;

  localparam int Size     = 32;
  localparam int TagWidth = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic                in_signed;
  logic [Size-1:0]     a;
  logic [Size-1:0]     b;
  logic [TagWidth-1:0] in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [Size-1:0]     c;
  logic [Size-1:0]     remainder;
  logic                div_by_zero;
  logic [TagWidth-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  seq_divider #(.Size(Size), .TagWidth(TagWidth)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .a(a), .b(b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .remainder(remainder), .div_by_zero(div_by_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder
  // taking the dividend's sign; b == 0 gives all ones / dividend.
  task automatic model(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] qc, output logic [31:0] qr, output logic qz);
    longint sa, sb, q, r;
    if (bv == 0) begin
      qc = '1; qr = av; qz = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
      end else begin
        sa = longint'({32'b0, av});
        sb = longint'({32'b0, bv});
      end
      q  = sa / sb;
      r  = sa % sb;
      qc = q[31:0];
      qr = r[31:0];
      qz = 1'b0;
    end
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] tg, input int stall);
    logic [31:0] ec, er;
    logic        ez;
    int          cyc;
    int          exp_lat;
    model(sgn, av, bv, ec, er, ez);
    exp_lat = (bv == 0) ? 1 : Size + 2;
    @(negedge clk);
    in_valid = 1'b1; in_signed = sgn; a = av; b = bv; in_tag = tg; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; in_signed = ~sgn; in_tag = 5'($urandom);
    cyc = 1;
    while (!out_valid && cyc < Size + 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    check("c", 64'(c), 64'(ec));
    check("remainder", 64'(remainder), 64'(er));
    check("div_by_zero", 64'(div_by_zero), 64'(ez));
    check("out_tag", 64'(out_tag), 64'(tg));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_c", 64'(c), 64'(ec));
      check("stall_rem", 64'(remainder), 64'(er));
      check("stall_dbz", 64'(div_by_zero), 64'(ez));
      check("stall_tag", 64'(out_tag), 64'(tg));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    logic [31:0] ra, rb;
    reset = 1'b0; in_valid = 1'b0; in_signed = 1'b0; a = '0; b = '0;
    in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_c", 64'(c), 64'd0);
    check("rst_rem", 64'(remainder), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-operation abandons it
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b0; a = 32'd1000; b = 32'd3; in_tag = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_c", 64'(c), 64'd0);
    check("abort_rem", 64'(remainder), 64'd0);
    check("abort_tag", 64'(out_tag), 64'd0);
    seen = 1'b0;
    repeat (Size + 10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 64'(seen), 64'd0);

    run_op(1'b0, 32'd100, 32'd7, 5'd17, 0);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 5'd3, 0);
    run_op(1'b0, 32'hFFFFFFF9, 32'd2, 5'd4, 0);
    run_op(1'b1, 32'h12345678, 32'd0, 5'd5, 0);
    run_op(1'b0, 32'h12345678, 32'd0, 5'd6, 0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd7, 0);
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, 5'd8, 0);
    run_op(1'b1, 32'd77, 32'hFFFFFFF6, 5'd30, 10);
    run_op(1'b0, 32'd5, 32'd9, 5'd31, 1);

    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(1'($urandom), ra, rb, 5'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
